wb_port_arbiter_2: RTL and testbench

//  Merges the two writeback lanes of the two-issue pipeline onto a single register-file write port.

---
 rtl/wb_port_arbiter_2_if.sv | 31 +++
 rtl/wb_port_arbiter_2.sv | 113 +++++++++++
 tb/tb_wb_port_arbiter_2.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_2_if.sv
// Writeback-lane interface between the two MEM/WB stages, the arbiter and the register file.
// The pipeline side is the master and the arbiter is the slave.
interface wb_port_arbiter_2_if #(
  parameter int unsigned REG_DW = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic              l0_wb_en_i;
  logic [REG_AW-1:0] l0_wb_addr_i;
  logic [REG_DW-1:0] l0_wb_data_i;
  logic              l1_wb_en_i;
  logic [REG_AW-1:0] l1_wb_addr_i;
  logic [REG_DW-1:0] l1_wb_data_i;
  logic              wb_en_o;
  logic [REG_AW-1:0] wb_addr_o;
  logic [REG_DW-1:0] wb_data_o;
  logic              busy_o;

  modport master (
    output in_valid_i, l0_wb_en_i, l0_wb_addr_i, l0_wb_data_i,
    output l1_wb_en_i, l1_wb_addr_i, l1_wb_data_i,
    input  in_ready_o, wb_en_o, wb_addr_o, wb_data_o, busy_o
  );

  modport slave (
    input  in_valid_i, l0_wb_en_i, l0_wb_addr_i, l0_wb_data_i,
    input  l1_wb_en_i, l1_wb_addr_i, l1_wb_data_i,
    output in_ready_o, wb_en_o, wb_addr_o, wb_data_o, busy_o
  );
endinterface

// File: rtl/wb_port_arbiter_2.sv
// Merges two writeback lanes onto one register-file write port through a pair FIFO,
// draining lane0 then lane1 per entry and dropping x0 and same-pair-overwritten writes.
module wb_port_arbiter_2 #(
  parameter int unsigned REG_DW = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_2_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef struct packed {
    logic              en0;
    logic [REG_AW-1:0] addr0;
    logic [REG_DW-1:0] data0;
    logic              en1;
    logic [REG_AW-1:0] addr1;
    logic [REG_DW-1:0] data1;
  } pair_t;

  typedef enum logic {StPh0, StPh1} phase_e;

  pair_t             mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  phase_e            phase_q;
  logic              wb_en_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [REG_DW-1:0] wb_data_q;

  pair_t head;
  logic  need0, need1, push, pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PtrW + 1)'(DEPTH));

  always_comb begin
    head  = mem_q[rd_ptr_q];
    // lane0 is dead if the younger lane writes the same register in the same pair
    need0 = head.en0 && (head.addr0 != '0) && !(head.en1 && (head.addr1 == head.addr0));
    need1 = head.en1 && (head.addr1 != '0);
    push  = bus.in_valid_i && !full;
    pop   = 1'b0;
    if (!empty) begin
      pop = (phase_q == StPh1) || !(need0 && need1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{en0:   bus.l0_wb_en_i, addr0: bus.l0_wb_addr_i,
                           data0: bus.l0_wb_data_i, en1: bus.l1_wb_en_i,
                           addr1: bus.l1_wb_addr_i, data1: bus.l1_wb_data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      phase_q   <= StPh0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase

      if (empty) begin
        wb_en_q <= 1'b0;
        phase_q <= StPh0;
      end else begin
        unique case (phase_q)
          StPh0: begin
            if (need0) begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= head.addr0;
              wb_data_q <= head.data0;
              if (need1) phase_q <= StPh1;
            end else if (need1) begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= head.addr1;
              wb_data_q <= head.data1;
            end else begin
              wb_en_q <= 1'b0;
            end
          end
          StPh1: begin
            wb_en_q   <= 1'b1;
            wb_addr_q <= head.addr1;
            wb_data_q <= head.data1;
            phase_q   <= StPh0;
          end
          default: phase_q <= StPh0;
        endcase
      end
    end
  end

  assign bus.in_ready_o = !full;
  assign bus.wb_en_o    = wb_en_q;
  assign bus.wb_addr_o  = wb_addr_q;
  assign bus.wb_data_o  = wb_data_q;
  assign bus.busy_o     = !empty || wb_en_q;
endmodule

// File: tb/tb_wb_port_arbiter_2.sv
// Self-checking bench for wb_port_arbiter_2: a write-list reference model checked every cycle,
// a table of single-pair vectors, and hand sequences for reset, latency and back-pressure.
module tb_wb_port_arbiter_2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_2_if #(.REG_DW(32), .REG_AW(5)) bus ();

  wb_port_arbiter_2 #(.REG_DW(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: each accepted pair becomes a list of 0..2 surviving writes; a pair
  // occupies the port for max(1, writes) cycles.
  typedef struct packed {
    int          n;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
  } ment_t;

  ment_t       mq[$];
  int          prog = 0;
  logic        exp_en = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [36:0] seen[$];

  typedef struct packed {
    logic        e0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] d1;
    int          n;
    logic [4:0]  xa0;
    logic [31:0] xd0;
    logic [4:0]  xa1;
    logic [31:0] xd1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ment_t mk(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    ment_t m;
    m = '0;
    if (e0 && a0 != 0 && !(e1 && a1 == a0)) begin
      m.a0 = a0; m.d0 = d0; m.n = 1;
    end
    if (e1 && a1 != 0) begin
      if (m.n == 0) begin
        m.a0 = a1; m.d0 = d1;
      end else begin
        m.a1 = a1; m.d1 = d1;
      end
      m.n = m.n + 1;
    end
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    prog = 0;
    exp_en = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic model_edge();
    logic do_push;
    int   cost;
    do_push = bus.in_valid_i && (mq.size() != DEPTH);
    exp_en = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].n > 0) begin
        exp_en   = 1'b1;
        exp_addr = (prog == 0) ? mq[0].a0 : mq[0].a1;
        exp_data = (prog == 0) ? mq[0].d0 : mq[0].d1;
      end
      prog++;
      cost = (mq[0].n > 1) ? mq[0].n : 1;
      if (prog >= cost) begin
        void'(mq.pop_front());
        prog = 0;
      end
    end
    if (do_push)
      mq.push_back(mk(bus.l0_wb_en_i, bus.l0_wb_addr_i, bus.l0_wb_data_i,
                      bus.l1_wb_en_i, bus.l1_wb_addr_i, bus.l1_wb_data_i));
  endtask

  task automatic check_outputs();
    chk("wb_en", 64'(bus.wb_en_o), 64'(exp_en));
    chk("wb_addr", 64'(bus.wb_addr_o), 64'(exp_addr));
    chk("wb_data", 64'(bus.wb_data_o), 64'(exp_data));
    chk("in_ready", 64'(bus.in_ready_o), 64'(mq.size() != DEPTH));
    chk("busy", 64'(bus.busy_o), 64'((mq.size() != 0) || exp_en));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (bus.wb_en_o) seen.push_back({bus.wb_addr_o, bus.wb_data_o});
  endtask

  task automatic set_pair(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    bus.l0_wb_en_i = e0; bus.l0_wb_addr_i = a0; bus.l0_wb_data_i = d0;
    bus.l1_wb_en_i = e1; bus.l1_wb_addr_i = a1; bus.l1_wb_data_i = d1;
  endtask

  task automatic do_reset();
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wb_en", 64'(bus.wb_en_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h11,  1'b1, 5'd6, 32'h22,   2, 5'd5,  32'h11,  5'd6, 32'h22};
    vecs[1] = '{1'b1, 5'd7,  32'hAA,  1'b1, 5'd7, 32'hBB,   1, 5'd7,  32'hBB,  5'd0, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'h33,  1'b0, 5'd9, 32'h99,   0, 5'd0,  32'h0,   5'd0, 32'h0};
    vecs[3] = '{1'b1, 5'd3,  32'h44,  1'b0, 5'd3, 32'h45,   1, 5'd3,  32'h44,  5'd0, 32'h0};
    vecs[4] = '{1'b0, 5'd4,  32'h50,  1'b1, 5'd9, 32'h55,   1, 5'd9,  32'h55,  5'd0, 32'h0};
    vecs[5] = '{1'b1, 5'd8,  32'h66,  1'b1, 5'd0, 32'h77,   1, 5'd8,  32'h66,  5'd0, 32'h0};
    vecs[6] = '{1'b1, 5'd0,  32'h1,   1'b1, 5'd0, 32'h2,    0, 5'd0,  32'h0,   5'd0, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hDEAD, 1'b1, 5'd1, 32'hBEEF, 2, 5'd31, 32'hDEAD, 5'd1, 32'hBEEF};

    set_pair(1'b0, '0, '0, 1'b0, '0, '0);
    bus.in_valid_i = 1'b0;
    do_reset();
    repeat (5) step();
    chk("idle_no_writes", 64'(seen.size()), 64'd0);

    // Latency of a dual-write pair: writes after N+1 and N+2, idle after N+3
    set_pair(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    step();
    chk("lat_n1_en", 64'(bus.wb_en_o), 64'd1);
    chk("lat_n1_addr", 64'(bus.wb_addr_o), 64'd5);
    chk("lat_n1_data", 64'(bus.wb_data_o), 64'h11);
    step();
    chk("lat_n2_addr", 64'(bus.wb_addr_o), 64'd6);
    chk("lat_n2_data", 64'(bus.wb_data_o), 64'h22);
    chk("lat_n2_busy", 64'(bus.busy_o), 64'd1);
    step();
    chk("lat_n3_busy", 64'(bus.busy_o), 64'd0);
    chk("lat_n3_en", 64'(bus.wb_en_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      seen.delete();
      set_pair(vecs[i].e0, vecs[i].a0, vecs[i].d0, vecs[i].e1, vecs[i].a1, vecs[i].d1);
      bus.in_valid_i = 1'b1;
      step();
      bus.in_valid_i = 1'b0;
      step();
      if (vecs[i].n == 0) chk($sformatf("vec%0d_pop_1cyc", i), 64'(bus.busy_o), 64'd0);
      repeat (3) step();
      chk($sformatf("vec%0d_nwrites", i), 64'(seen.size()), 64'(vecs[i].n));
      if (vecs[i].n > 0 && seen.size() > 0)
        chk($sformatf("vec%0d_w0", i), 64'(seen[0]), 64'({vecs[i].xa0, vecs[i].xd0}));
      if (vecs[i].n > 1 && seen.size() > 1)
        chk($sformatf("vec%0d_w1", i), 64'(seen[1]), 64'({vecs[i].xa1, vecs[i].xd1}));
    end

    // Back-pressure: stream dual-write pairs until the FIFO fills
    begin
      int guard = 0;
      seen.delete();
      bus.in_valid_i = 1'b1;
      while (bus.in_ready_o && guard < 12) begin
        set_pair(1'b1, 5'(10 + guard), 32'h100 + 32'(guard), 1'b1, 5'(20 + guard),
                 32'h200 + 32'(guard));
        step();
        guard++;
      end
      chk("bp_full_reached", 64'(bus.in_ready_o), 64'd0);
      set_pair(1'b1, 5'd2, 32'hBAD0, 1'b1, 5'd3, 32'hBAD1);
      step();
      bus.in_valid_i = 1'b0;
      guard = 0;
      while (!bus.in_ready_o && guard < 3) begin
        step();
        guard++;
      end
      chk("bp_ready_returns", 64'(bus.in_ready_o), 64'd1);
      repeat (14) step();
      for (int k = 0; k < seen.size(); k++) begin
        chk("bp_no_rejected_write", 64'(seen[k][36:32] == 5'd2 || seen[k][36:32] == 5'd3),
            64'd0);
      end
    end

    // Reset while entries are pending
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_pair(1'b1, 5'(k + 1), 32'hC0 + 32'(k), 1'b1, 5'(k + 11), 32'hD0 + 32'(k));
      step();
    end
    chk("mid_pending", 64'(mq.size() >= 3), 64'd1);
    do_reset();
    seen.delete();
    repeat (5) step();
    chk("post_rst_no_stale", 64'(seen.size()), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.in_valid_i = 1'($urandom_range(0, 1));
      set_pair(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      step();
    end
    bus.in_valid_i = 1'b0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
